// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between an upstream pipeline stage, ctrl and the inter-stage register.
// The master side drives in_*/stall/flush/perf_clr; the slave side is the register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 6,
  parameter int CNT_W      = 2,
  parameter int ACC_W      = 64,
  parameter int PERF_W     = 16
);
  logic                  in_valid;
  logic [4:0]            in_wd;
  logic                  in_wreg;
  logic [DATA_W-1:0]     in_data;
  logic [CNT_W-1:0]      in_cnt;
  logic [ACC_W-1:0]      in_acc;
  logic [NUM_STAGES-1:0] stall;
  logic                  flush;
  logic                  perf_clr;
  logic                  out_valid;
  logic [4:0]            out_wd;
  logic                  out_wreg;
  logic [DATA_W-1:0]     out_data;
  logic [CNT_W-1:0]      cnt_o;
  logic [ACC_W-1:0]      acc_o;
  logic [PERF_W-1:0]     bubble_cnt;

  modport master (
    output in_valid, in_wd, in_wreg, in_data, in_cnt, in_acc, stall, flush, perf_clr,
    input  out_valid, out_wd, out_wreg, out_data, cnt_o, acc_o, bubble_cnt
  );

  modport slave (
    input  in_valid, in_wd, in_wreg, in_data, in_cnt, in_acc, stall, flush, perf_clr,
    output out_valid, out_wd, out_wreg, out_data, cnt_o, acc_o, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush, stall-driven bubble insertion, multi-cycle state
// feedback (cnt/acc) and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 6,
  parameter int STAGE_IDX  = 3,
  parameter int CNT_W      = 2,
  parameter int ACC_W      = 64,
  parameter int PERF_W     = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_reg_if.slave  bus
);

  generate
    if (STAGE_IDX < 0 || STAGE_IDX > NUM_STAGES - 2) begin : g_bad_stage_idx
      $error("pipe_stage_reg: STAGE_IDX must lie in 0..NUM_STAGES-2");
    end
  endgenerate

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

  logic w_up;
  logic w_dn;
  logic w_bubble;
  logic w_unused_stall;

  assign w_up     = bus.stall[STAGE_IDX];
  assign w_dn     = bus.stall[STAGE_IDX+1];
  assign w_bubble = w_up & ~w_dn & ~bus.flush;
  // Only two stall bits matter to this instance.
  assign w_unused_stall = ^bus.stall;

  logic              r_valid_p1;
  logic [4:0]        r_wd_p1;
  logic              r_wreg_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic [CNT_W-1:0]  r_cnt_p1;
  logic [ACC_W-1:0]  r_acc_p1;
  logic [PERF_W-1:0] r_bubble_cnt;

  // Stage boundary: upstream -> registered outputs. Priority flush > bubble > pass > hold;
  // the illegal up=0,dn=1 pattern falls into pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_p1 <= 1'b0;
      r_wd_p1    <= 5'd0;
      r_wreg_p1  <= 1'b0;
      r_data_p1  <= '0;
      r_cnt_p1   <= '0;
      r_acc_p1   <= '0;
    end else if (bus.flush) begin
      r_valid_p1 <= 1'b0;
      r_wd_p1    <= 5'd0;
      r_wreg_p1  <= 1'b0;
      r_data_p1  <= '0;
      r_cnt_p1   <= '0;
      r_acc_p1   <= '0;
    end else if (w_up && !w_dn) begin
      r_valid_p1 <= 1'b0;
      r_wd_p1    <= 5'd0;
      r_wreg_p1  <= 1'b0;
      r_data_p1  <= '0;
      r_cnt_p1   <= bus.in_cnt;
      r_acc_p1   <= bus.in_acc;
    end else if (!w_up) begin
      r_valid_p1 <= bus.in_valid;
      r_wd_p1    <= bus.in_wd;
      r_wreg_p1  <= bus.in_wreg;
      r_data_p1  <= bus.in_data;
      r_cnt_p1   <= '0;
      r_acc_p1   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (bus.perf_clr) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign bus.out_valid  = r_valid_p1;
  assign bus.out_wd     = r_wd_p1;
  assign bus.out_wreg   = r_wreg_p1;
  assign bus.out_data   = r_data_p1;
  assign bus.cnt_o      = r_cnt_p1;
  assign bus.acc_o      = r_acc_p1;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (STAGE_IDX=3, PERF_W=4 so saturation is reachable).
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int NS     = 6;
  localparam int CNT_W  = 2;
  localparam int ACC_W  = 64;
  localparam int PERF_W = 4;
  localparam int OBS_W  = 1 + 5 + 1 + DATA_W + CNT_W + ACC_W + PERF_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .NUM_STAGES(NS), .CNT_W(CNT_W),
                      .ACC_W(ACC_W), .PERF_W(PERF_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .NUM_STAGES(NS), .STAGE_IDX(3), .CNT_W(CNT_W),
                   .ACC_W(ACC_W), .PERF_W(PERF_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [OBS_W-1:0]  obs;
  logic [OBS_W-1:0]  exp_v;
  logic [PERF_W-1:0] exp_bub;
  int n_pass = 0;
  int n_tot  = 0;

  assign obs = {bus.out_valid, bus.out_wd, bus.out_wreg, bus.out_data,
                bus.cnt_o, bus.acc_o, bus.bubble_cnt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wr,
                       input logic [31:0] d, input logic [1:0] c, input logic [63:0] a,
                       input logic [5:0] st, input logic fl, input logic pc);
    bus.in_valid = v;  bus.in_wd  = wd; bus.in_wreg = wr; bus.in_data  = d;
    bus.in_cnt   = c;  bus.in_acc = a;  bus.stall   = st; bus.flush    = fl;
    bus.perf_clr = pc;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd31, 1'b1, 32'hFFFF_FFFF, 2'd3, 64'hFFFF, 6'b111111, 1'b1, 1'b1);
    #2;
    exp_v = '0; n_tot++;
    if (obs !== exp_v) $display("FAIL reset_initial: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd21, 1'b1, 32'hA5A5_0001, 2'd2, 64'h77, 6'b000000, 1'b0, 1'b0);
    tick();
    exp_v = {1'b1, 5'd21, 1'b1, 32'hA5A5_0001, 2'd0, 64'd0, 4'd0}; n_tot++;
    if (obs !== exp_v) $display("FAIL reset_release_pass: got %h want %h", obs, exp_v); else n_pass++;
    drive(1'b1, 5'd21, 1'b1, 32'hA5A5_0001, 2'd3, 64'hABC, 6'b001111, 1'b0, 1'b0);
    tick();
    exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd3, 64'hABC, 4'd1}; n_tot++;
    if (obs !== exp_v) $display("FAIL reset_pre_bubble: got %h want %h", obs, exp_v); else n_pass++;
    rst_n = 1'b0;
    #1;
    exp_v = '0; n_tot++;
    if (obs !== exp_v) $display("FAIL reset_async_midcycle: got %h want %h", obs, exp_v); else n_pass++;
    tick();
    rst_n = 1'b1;
    exp_bub = '0;
  endtask

  task automatic test_pass();
    drive(1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 2'd3, 64'h5, 6'b000000, 1'b0, 1'b0);
    tick();
    exp_v = {1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 2'd0, 64'd0, exp_bub}; n_tot++;
    if (obs !== exp_v) $display("FAIL pass_basic: got %h want %h", obs, exp_v); else n_pass++;
    drive(1'b0, 5'd12, 1'b0, 32'h0BAD_F00D, 2'd1, 64'h9, 6'b000111, 1'b0, 1'b0);
    tick();
    exp_v = {1'b0, 5'd12, 1'b0, 32'h0BAD_F00D, 2'd0, 64'd0, exp_bub}; n_tot++;
    if (obs !== exp_v) $display("FAIL pass_invalid: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_bubble();
    drive(1'b1, 5'd9, 1'b1, 32'h1111_2222, 2'd1, 64'h1234, 6'b001111, 1'b0, 1'b0);
    tick();
    exp_bub = exp_bub + 4'd1;
    exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd1, 64'h1234, exp_bub}; n_tot++;
    if (obs !== exp_v) $display("FAIL bubble_basic: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 3), 1'b1, 32'hC0DE_0000 + i, 2'(i), 64'h100 + i, 6'b011111, 1'b0, 1'b0);
      tick();
      exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd1, 64'h1234, exp_bub}; n_tot++;
      if (obs !== exp_v) $display("FAIL hold_after_bubble_%0d: got %h want %h", i, obs, exp_v); else n_pass++;
    end
    drive(1'b1, 5'd17, 1'b1, 32'h5555_AAAA, 2'd2, 64'h42, 6'b000000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 5'd1, 1'b0, 32'h0 + i, 2'd3, 64'h99, 6'b111111, 1'b0, 1'b0);
      tick();
      exp_v = {1'b1, 5'd17, 1'b1, 32'h5555_AAAA, 2'd0, 64'd0, exp_bub}; n_tot++;
      if (obs !== exp_v) $display("FAIL hold_after_pass_%0d: got %h want %h", i, obs, exp_v); else n_pass++;
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd4, 1'b1, 32'h0000_00F0, 2'd1, 64'h1234, 6'b001111, 1'b0, 1'b0);
    tick();
    exp_bub = exp_bub + 4'd1;
    drive(1'b1, 5'd4, 1'b1, 32'h0000_00F0, 2'd2, 64'hFEED, 6'b001111, 1'b1, 1'b0);
    tick();
    exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 64'd0, exp_bub}; n_tot++;
    if (obs !== exp_v) $display("FAIL flush_with_bubble: got %h want %h", obs, exp_v); else n_pass++;
    drive(1'b1, 5'd30, 1'b1, 32'h1357_9BDF, 2'd0, 64'd0, 6'b000000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd30, 1'b1, 32'h1357_9BDF, 2'd0, 64'd0, 6'b011111, 1'b1, 1'b0);
    tick();
    exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 64'd0, exp_bub}; n_tot++;
    if (obs !== exp_v) $display("FAIL flush_over_hold: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_illegal_stall();
    drive(1'b1, 5'd19, 1'b1, 32'h2468_ACE0, 2'd3, 64'h8, 6'b010000, 1'b0, 1'b0);
    tick();
    exp_v = {1'b1, 5'd19, 1'b1, 32'h2468_ACE0, 2'd0, 64'd0, exp_bub}; n_tot++;
    if (obs !== exp_v) $display("FAIL illegal_up0_dn1_pass: got %h want %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_saturate();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 64'd0, 6'b000000, 1'b0, 1'b1);
    tick();
    n_tot++;
    if (bus.bubble_cnt !== 4'd0) $display("FAIL perf_clr_idle: got %0d want 0", bus.bubble_cnt); else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 5'd2, 1'b1, 32'hFACE, 2'd2, 64'hBEEF, 6'b001111, 1'b0, 1'b0);
      tick();
      if (i == 14 || i == 15 || i == 20) begin
        n_tot++;
        if (bus.bubble_cnt !== ((i < 15) ? 4'(i) : 4'd15))
          $display("FAIL saturate_after_%0d: got %0d want %0d", i, bus.bubble_cnt, (i < 15) ? i : 15);
        else n_pass++;
      end
    end
    exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd2, 64'hBEEF, 4'd15}; n_tot++;
    if (obs !== exp_v) $display("FAIL saturate_outputs: got %h want %h", obs, exp_v); else n_pass++;
    drive(1'b1, 5'd2, 1'b1, 32'hFACE, 2'd1, 64'hBEEF, 6'b001111, 1'b0, 1'b1);
    tick();
    exp_v = {1'b0, 5'd0, 1'b0, 32'd0, 2'd1, 64'hBEEF, 4'd0}; n_tot++;
    if (obs !== exp_v) $display("FAIL perf_clr_over_bubble: got %h want %h", obs, exp_v); else n_pass++;
    drive(1'b1, 5'd2, 1'b1, 32'hFACE, 2'd1, 64'hBEEF, 6'b001111, 1'b0, 1'b0);
    tick();
    n_tot++;
    if (bus.bubble_cnt !== 4'd1) $display("FAIL count_after_clear: got %0d want 1", bus.bubble_cnt); else n_pass++;
  endtask

  initial begin
    exp_bub = '0;
    test_reset();
    test_pass();
    test_bubble();
    test_hold();
    test_flush();
    test_illegal_stall();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish want finish before 20000");
    $fatal(1, "timeout");
  end
endmodule
